// File: rtl/rst_sequencer.sv
// Staged reset release with hold time, per-stage gaps and a debounced
// pushbutton that re-runs the whole release sequence.
module rst_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int N_STAGES    = 3,
  parameter int DEBOUNCE    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn,
  output logic [N_STAGES-1:0] rst_stage,
  output logic                busy,
  output logic                done,
  output logic [7:0]          btn_count
);

  typedef enum logic [1:0] {
    HOLD,
    STAGE,
    RUN
  } state_t;

  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(STAGE_GAP - 1);
  localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE - 1);
  localparam logic [3:0]  STAGE_LAST = 4'(N_STAGES - 1);
  localparam logic        ONE_STAGE  = (N_STAGES == 1);

  state_t              state;
  state_t              state_n;
  logic [15:0]         hold_cnt;
  logic [15:0]         hold_n;
  logic [7:0]          gap_cnt;
  logic [7:0]          gap_n;
  logic [3:0]          stage_cnt;
  logic [3:0]          stage_n;
  logic [N_STAGES-1:0] rst_stage_n;
  logic                done_n;
  logic [7:0]          btn_count_n;

  logic       s1;
  logic       s2;
  logic       deb;
  logic       press;
  logic [7:0] db_cnt;
  logic       db_flip;

  assign db_flip = (s2 != deb) && (db_cnt == DB_LAST);

  // press is a registered 0->1 event of the debounced button
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      deb    <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= db_flip & ~deb;
      if (s2 == deb || db_flip) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
      if (db_flip) begin
        deb <= ~deb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      stage_cnt <= '0;
      rst_stage <= '1;
      busy      <= 1'b1;
      done      <= 1'b0;
      btn_count <= '0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      gap_cnt   <= gap_n;
      stage_cnt <= stage_n;
      rst_stage <= rst_stage_n;
      busy      <= |rst_stage_n;
      done      <= done_n;
      btn_count <= btn_count_n;
    end
  end

  // a press overrides any release or done due on the same edge
  always_comb begin
    state_n     = state;
    hold_n      = hold_cnt;
    gap_n       = gap_cnt;
    stage_n     = stage_cnt;
    rst_stage_n = rst_stage;
    done_n      = 1'b0;
    btn_count_n = btn_count;
    if (press) begin
      state_n     = HOLD;
      hold_n      = '0;
      gap_n       = '0;
      stage_n     = '0;
      rst_stage_n = '1;
      if (btn_count != 8'hFF) begin
        btn_count_n = btn_count + 8'd1;
      end
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            rst_stage_n[0] = 1'b0;
            stage_n        = 4'd1;
            gap_n          = '0;
            state_n        = ONE_STAGE ? RUN : STAGE;
            done_n         = ONE_STAGE;
          end else begin
            hold_n = hold_cnt + 16'd1;
          end
        end
        STAGE: begin
          if (gap_cnt == GAP_LAST) begin
            for (int i = 0; i < N_STAGES; i++) begin
              if (4'(i) == stage_cnt) begin
                rst_stage_n[i] = 1'b0;
              end
            end
            stage_n = stage_cnt + 4'd1;
            gap_n   = '0;
            if (stage_cnt == STAGE_LAST) begin
              state_n = RUN;
              done_n  = 1'b1;
            end
          end else begin
            gap_n = gap_cnt + 8'd1;
          end
        end
        RUN: begin
          rst_stage_n = '0;
        end
        default: begin
          state_n = HOLD;
        end
      endcase
    end
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Consumes the one-shot power-on flag (inverted, as `rst`) and produces staged, per-subsystem synchronous resets, e.g. core, video timing, font ROM/renderer.
- Holds all stages in reset for a minimum time, then releases them one by one in a fixed order.
- Also accepts a raw pushbutton that, once debounced, re-runs the whole sequence.
- Sits between the power-on generator and every other block in the design.

Parameters:
- HOLD_CYCLES, 16: cycles all stages stay asserted after reset or button release; valid range 1..65535.
- STAGE_GAP, 4: cycles between release of successive stages; valid range 1..255.
- N_STAGES, 3: number of reset outputs; valid range 1..8.
- DEBOUNCE, 8: consecutive stable cycles required before the button state is accepted; valid range 2..255.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset. Driven from the inverted power-on flag.
- btn, input, 1: raw pushbutton, active-high, asynchronous to clk.
- rst_stage, output, N_STAGES: active-high synchronous resets. Bit 0 is released first.
- busy, output, 1: high while any bit of rst_stage is asserted.
- done, output, 1: one-cycle pulse when the last stage is released.
- btn_count, output, 8: number of accepted button restarts; saturates at 255.

Behaviour:
- Reset: rst is sampled on the clk rising edge and takes priority over everything else. While rst=1:
  - rst_stage = all ones, busy=1, done=0, btn_count=0.
  - State = HOLD; hold counter and stage counter = 0.
  - Synchronizer flops = 0; debounce counter = 0; debounced button = 0.
  - Assertion mid-sequence or mid-RUN takes effect at the next edge.
- Edge numbering: "edge 1" is the first rising edge at which rst is sampled 0 (or the edge at which a HOLD restart begins counting).
- Button synchronizer: two flops, btn -> s1 -> s2. No logic between the two flops.
- Debounce:
  - Counter clears whenever s2 equals the debounced value; otherwise it increments.
  - When s2 differs and the counter equals DEBOUNCE-1, the debounced value toggles at that edge and the counter clears.
  - Only a 0->1 transition of the debounced value is a press. A held button yields exactly one press; release is debounced the same way.
  - Press latency: btn first sampled 1 at edge E0 -> debounced=1 after edge E0+DEBOUNCE+1 -> rst_stage all ones after edge E0+DEBOUNCE+2.
- State machine:
  - HOLD:
    - All stages asserted; hold counter increments each edge.
    - After edge HOLD_CYCLES: rst_stage[0] <= 0, stage counter = 1, go to STAGE (or RUN if N_STAGES=1).
  - STAGE:
    - Gap counter increments each edge.
    - Every STAGE_GAP edges: release rst_stage[stage counter] and increment the stage counter.
    - Releasing the last bit goes to RUN.
    - Stage k releases after edge HOLD_CYCLES + k*STAGE_GAP.
  - RUN: all stages 0, busy=0. Waits for a press.
- done: 1 for exactly the cycle following the edge that clears rst_stage[N_STAGES-1]. busy falls at that same edge.
- Press in any state (HOLD, STAGE or RUN):
  - At the next edge, all of rst_stage goes to ones, busy=1, done=0, hold and stage counters clear, state = HOLD.
  - btn_count increments, saturating at 255.
  - A press on the same edge that would release a stage or raise done wins: the release/done does not occur.
- rst and a press on the same edge: rst wins and btn_count = 0.
- Released stages never glitch. All outputs are registered.

Test Plan (defaults):
1. rst=1 for 5 edges, then 0, btn=0.
   - rst_stage=111 through edge 16.
   - 110 after edge 16, 100 after edge 20, 000 after edge 24.
   - done=1 only after edge 24; busy=0 from after edge 24.
2. In RUN, btn high for 5 cycles then low.
   - rst_stage stays 000, busy=0, btn_count=0, done never pulses.
3. In RUN, btn high from edge E0, held 100 cycles.
   - rst_stage=111 after edge E0+10; btn_count=1.
   - Full release repeats: stages fall 16/20/24 edges later.
   - Exactly one done pulse; no second restart on release.
4. Press accepted while rst_stage=110 (STAGE).
   - Next edge rst_stage=111 and the hold count restarts; btn_count=1.
   - Release timing is measured from the restart.
5. rst raised while rst_stage=100 with btn_count=3.
   - Next edge: rst_stage=111, btn_count=0, busy=1, done=0, debounce state cleared.
6. 260 debounced presses, each followed by a full release.
   - btn_count reaches 255 and holds.
   - Every press still restarts the sequence.
